// File: rtl/pe_mem_req_arbiter_if.sv
// Request/response and memory-port bundle for the PE local-memory arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface pe_mem_req_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 64
);
  logic              dma_req_valid;
  logic              dma_req_ready;
  logic              dma_req_wr;
  logic              dma_req_last;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [DATA_W-1:0] dma_req_wdata;
  logic              dma_rsp_valid;
  logic [DATA_W-1:0] dma_rsp_data;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_wr;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  dma_req_valid, dma_req_wr, dma_req_last, dma_req_addr, dma_req_wdata,
    input  ls_req_valid, ls_req_wr, ls_req_addr, ls_req_wdata,
    input  mem_rdata,
    output dma_req_ready, dma_rsp_valid, dma_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output dma_req_valid, dma_req_wr, dma_req_last, dma_req_addr, dma_req_wdata,
    output ls_req_valid, ls_req_wr, ls_req_addr, ls_req_wdata,
    output mem_rdata,
    input  dma_req_ready, dma_rsp_valid, dma_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pe_mem_req_arbiter.sv
// Arbitrates a PE's single-port local memory between DMA and load/store, with
// bounded DMA burst locking and a latency-matched read-owner pipeline.
module pe_mem_req_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input logic                 clk,
  input logic                 reset_poweron,
  pe_mem_req_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, DMA_LOCK} state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             dma_grant, ls_grant;
  logic             ls_break;

  logic              cs_q, we_q, owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_LAT-1:0] pipe_valid, pipe_owner;
  logic              tail_dma, tail_ls;

  // last_grant: 0 = DMA won last, 1 = LS won last
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  assign ls_break = bus.ls_req_valid && (burst_cnt == CNT_MAX);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    dma_grant      = 1'b0;
    ls_grant       = 1'b0;
    if (!reset_poweron) begin
      case (state)
        IDLE: begin
          if (bus.dma_req_valid && (!bus.ls_req_valid || last_grant))
            dma_grant = 1'b1;
          else if (bus.ls_req_valid)
            ls_grant = 1'b1;
          if (dma_grant) begin
            last_grant_nxt = 1'b0;
            if (!bus.dma_req_last) begin
              state_nxt     = DMA_LOCK;
              burst_cnt_nxt = CNT_W'(1);
            end
          end else if (ls_grant) begin
            last_grant_nxt = 1'b1;
          end
        end
        DMA_LOCK: begin
          // A last beat still goes through on the cycle a starving LS would force a break.
          if (bus.dma_req_valid && (bus.dma_req_last || !ls_break)) begin
            dma_grant      = 1'b1;
            last_grant_nxt = 1'b0;
            if (burst_cnt != CNT_MAX)
              burst_cnt_nxt = burst_cnt + 1'b1;
            if (bus.dma_req_last) begin
              state_nxt     = IDLE;
              burst_cnt_nxt = '0;
            end
          end else if (ls_break) begin
            state_nxt      = IDLE;
            last_grant_nxt = 1'b0;
            burst_cnt_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.dma_req_ready = dma_grant;
  assign bus.ls_req_ready  = ls_grant;

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cs_q    <= dma_grant || ls_grant;
      we_q    <= dma_grant ? bus.dma_req_wr : (ls_grant && bus.ls_req_wr);
      owner_q <= ls_grant;
      if (dma_grant) begin
        addr_q  <= bus.dma_req_addr;
        wdata_q <= bus.dma_req_wdata;
      end else if (ls_grant) begin
        addr_q  <= bus.ls_req_addr;
        wdata_q <= bus.ls_req_wdata;
      end
    end
  end

  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Loaded while the read command is on the port, so the tail lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      pipe_valid[0] <= cs_q && !we_q;
      pipe_owner[0] <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

  assign tail_dma = pipe_valid[RD_LAT-1] && !pipe_owner[RD_LAT-1];
  assign tail_ls  = pipe_valid[RD_LAT-1] &&  pipe_owner[RD_LAT-1];

  assign bus.dma_rsp_valid = tail_dma;
  assign bus.dma_rsp_data  = tail_dma ? bus.mem_rdata : '0;
  assign bus.ls_rsp_valid  = tail_ls;
  assign bus.ls_rsp_data   = tail_ls ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_pe_mem_req_arbiter.sv
// Bench for pe_mem_req_arbiter: directed scenarios plus random traffic, checked
// every cycle against a rule-level arbitration model and a memory/response scoreboard.
module tb_pe_mem_req_arbiter;
  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 64;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic reset_poweron = 1'b1;
  always #5 clk = ~clk;

  pe_mem_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pe_mem_req_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    bit          to_ls;
    logic [63:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  bit          armed = 1'b0;

  bit          m_locked = 1'b0;
  int          m_beats = 0;
  bit          m_last_ls = 1'b1;
  bit          exp_cs = 1'b0, exp_we = 1'b0;
  logic [23:0] exp_addr = '0;
  logic [63:0] exp_wdata = '0;

  logic [63:0] rd_sched[16];
  bit          rd_sched_v[16];

  bit          burst_phase = 1'b0;
  int          burst_dma = 0;
  int          ls_after[$];

  bit          g_dma, g_ls, starve, exp_dv, exp_lv;
  logic [63:0] exp_data;
  rsp_t        r;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [23:0] a);
    return (a == 24'h10) ? 64'hA5A5 : {8'hC3, a, 8'h3C, ~a};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: returns data RD_LAT cycles after a read strobe, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (rd_sched_v[cyc % 16]) begin
      bus.mem_rdata = rd_sched[cyc % 16];
      rd_sched_v[cyc % 16] = 1'b0;
    end else begin
      bus.mem_rdata = rand64();
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("mem_cs", bus.mem_cs, exp_cs);
      checkOutput("mem_we", bus.mem_we, exp_we);
      if (exp_cs) begin
        checkOutput("mem_addr", bus.mem_addr, exp_addr);
        checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      if (bus.mem_cs === 1'b1 && bus.mem_we === 1'b0) begin
        rd_sched[(cyc + RD_LAT) % 16]   = data_of(bus.mem_addr);
        rd_sched_v[(cyc + RD_LAT) % 16] = 1'b1;
      end

      exp_dv = 1'b0;
      exp_lv = 1'b0;
      exp_data = '0;
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        r = rsp_q.pop_front();
        exp_dv = !r.to_ls;
        exp_lv = r.to_ls;
        exp_data = r.data;
      end
      checkOutput("dma_rsp_valid", bus.dma_rsp_valid, exp_dv);
      checkOutput("ls_rsp_valid", bus.ls_rsp_valid, exp_lv);
      if (exp_dv) checkOutput("dma_rsp_data", bus.dma_rsp_data, exp_data);
      if (exp_lv) checkOutput("ls_rsp_data", bus.ls_rsp_data, exp_data);

      g_dma = 1'b0;
      g_ls  = 1'b0;
      if (reset_poweron) begin
        m_locked  = 1'b0;
        m_beats   = 0;
        m_last_ls = 1'b1;
      end else if (!m_locked) begin
        if (bus.dma_req_valid && bus.ls_req_valid) begin
          if (m_last_ls) g_dma = 1'b1;
          else           g_ls  = 1'b1;
        end else begin
          g_dma = bus.dma_req_valid;
          g_ls  = bus.ls_req_valid;
        end
        if (g_dma) begin
          m_last_ls = 1'b0;
          if (!bus.dma_req_last) begin
            m_locked = 1'b1;
            m_beats  = 1;
          end
        end
        if (g_ls) m_last_ls = 1'b1;
      end else begin
        starve = bus.ls_req_valid && (m_beats >= MAX_BURST);
        if (bus.dma_req_valid && (bus.dma_req_last || !starve)) begin
          g_dma     = 1'b1;
          m_last_ls = 1'b0;
          m_beats   = (m_beats + 1 > MAX_BURST) ? MAX_BURST : m_beats + 1;
          if (bus.dma_req_last) m_locked = 1'b0;
        end else if (starve) begin
          m_locked  = 1'b0;
          m_last_ls = 1'b0;
        end
      end
      checkOutput("dma_req_ready", bus.dma_req_ready, g_dma);
      checkOutput("ls_req_ready", bus.ls_req_ready, g_ls);

      if (burst_phase && bus.dma_req_valid && bus.dma_req_ready) burst_dma++;
      if (burst_phase && bus.ls_req_valid && bus.ls_req_ready) ls_after.push_back(burst_dma);

      exp_cs    = g_dma || g_ls;
      exp_we    = g_dma ? bus.dma_req_wr : (g_ls && bus.ls_req_wr);
      exp_addr  = g_dma ? bus.dma_req_addr : bus.ls_req_addr;
      exp_wdata = g_dma ? bus.dma_req_wdata : bus.ls_req_wdata;
      if (exp_cs && !exp_we) rsp_q.push_back('{cyc + 1 + RD_LAT, g_ls, data_of(exp_addr)});

      if (reset_poweron) begin
        exp_cs = 1'b0;
        exp_we = 1'b0;
        rsp_q.delete();
      end
    end
  end

  task automatic applyStimulus(input bit dv, input bit dwr, input bit dlast,
                               input logic [23:0] daddr, input logic [63:0] dwd,
                               input bit lv, input bit lwr,
                               input logic [23:0] laddr, input logic [63:0] lwd,
                               output bit dacc, output bit lacc);
    bus.dma_req_valid = dv;
    bus.dma_req_wr    = dwr;
    bus.dma_req_last  = dlast;
    bus.dma_req_addr  = daddr;
    bus.dma_req_wdata = dwd;
    bus.ls_req_valid  = lv;
    bus.ls_req_wr     = lwr;
    bus.ls_req_addr   = laddr;
    bus.ls_req_wdata  = lwd;
    #3;
    dacc = dv && (bus.dma_req_ready === 1'b1);
    lacc = lv && (bus.ls_req_ready === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    bit da, la;
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0, da, la);
  endtask

  initial begin
    bit da, la;
    bit rv;
    int beat, lsg, guard;
    int exp_pos[3];
    exp_pos = '{16, 32, 40};

    bus.dma_req_valid = 0; bus.dma_req_wr = 0; bus.dma_req_last = 0;
    bus.dma_req_addr = '0; bus.dma_req_wdata = '0;
    bus.ls_req_valid = 0; bus.ls_req_wr = 0; bus.ls_req_addr = '0; bus.ls_req_wdata = '0;
    bus.mem_rdata = '0;

    @(posedge clk);
    #1;
    armed = 1'b1;
    idleCycles(2);
    reset_poweron = 1'b0;

    applyStimulus(1, 0, 1, 24'h10, rand64(), 0, 0, '0, '0, da, la);
    idleCycles(5);

    reset_poweron = 1'b1;
    idleCycles(1);
    reset_poweron = 1'b0;
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 1'($urandom), 1, 24'($urandom), rand64(),
                    1, 1'($urandom), 24'($urandom), rand64(), da, la);
    idleCycles(4);

    burst_phase = 1'b1;
    beat = 1; lsg = 0; guard = 0;
    while ((beat <= 40 || lsg < 3) && guard < 200) begin
      applyStimulus(beat <= 40, 1'($urandom), beat == 40, 24'(24'h1000 + beat), rand64(),
                    lsg < 3, 1'($urandom), 24'(24'h2000 + lsg), rand64(), da, la);
      if (da) beat++;
      if (la) lsg++;
      guard++;
    end
    burst_phase = 1'b0;
    checkOutput("burst_complete", 64'(guard < 200), 64'd1);
    checkOutput("burst_ls_grants", 64'(ls_after.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < ls_after.size())
        checkOutput($sformatf("burst_ls_after_%0d", i), 64'(ls_after[i]), 64'(exp_pos[i]));
    idleCycles(4);

    applyStimulus(1, 0, 1, 24'h1, rand64(), 0, 0, '0, '0, da, la);
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 24'h2, rand64(), da, la);
    idleCycles(6);

    for (int i = 0; i < 8; i++)
      applyStimulus(1'($urandom), 1, 1, 24'($urandom), rand64(),
                    1'($urandom), 1, 24'($urandom), rand64(), da, la);
    idleCycles(4);

    applyStimulus(1, 0, 1, 24'h30, rand64(), 0, 0, '0, '0, da, la);
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 24'h31, rand64(), da, la);
    reset_poweron = 1'b1;
    idleCycles(1);
    reset_poweron = 1'b0;
    idleCycles(4);
    applyStimulus(1, 0, 1, 24'h10, rand64(), 0, 0, '0, '0, da, la);
    idleCycles(5);

    for (int i = 0; i < 500; i++) begin
      rv = ($urandom_range(0, 99) == 0);
      reset_poweron = rv;
      applyStimulus(!rv && ($urandom_range(0, 3) != 0), 1'($urandom),
                    (i < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0),
                    24'($urandom), rand64(),
                    !rv && 1'($urandom), 1'($urandom), 24'($urandom), rand64(), da, la);
    end
    reset_poweron = 1'b0;
    idleCycles(8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
